// File: rtl/sys_defs.sv
// Shared definitions for the instruction cache controller: bus command encoding, XLEN and FSM states.
// ICACHE_PREFETCH_EN adds the next-line prefetch states to the state enum.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;
  localparam int XLEN = `XLEN;

  typedef enum logic [1:0] {
    BUS_NONE = 2'h0,
    BUS_LOAD = 2'h1
  } bus_cmd_e;

`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PF_REQ, PF_WAIT} icache_state_e;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} icache_state_e;
`endif
endpackage

// File: rtl/icache_ctrl_if.sv
// Memory-side bus of the instruction cache: request command/address out, response/tag/data back.
interface icache_ctrl_if;
  import sys_defs::*;

  bus_cmd_e        proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/icache_ctrl_mem.sv
// Direct-mapped line store (valid/tag/data): combinational read, synchronous write, async clear.
// ICACHE_PREFETCH_EN adds a second valid/tag probe used to decide on a next-line prefetch.
module icache_mem #(
  parameter int LINES = 32,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [63:0]      rd_data,
`ifdef ICACHE_PREFETCH_EN
  input  logic [IDX_W-1:0] probe_idx,
  output logic             probe_valid,
  output logic [TAG_W-1:0] probe_tag,
`endif
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [63:0]      wr_data
);
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [63:0]      data_q [LINES];
  logic [63:0]      data_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  // Tag and data are cleared with the valid bits so the read port shows zero under reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

`ifdef ICACHE_PREFETCH_EN
  assign probe_valid = valid_q[probe_idx];
  assign probe_tag   = tag_q[probe_idx];
`endif
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with a single outstanding line fill.
// ICACHE_PREFETCH_EN enables a one-line-ahead prefetch after each demand fill.
//
// state   | meaning
// IDLE    | serving hits; a miss without squash starts a request
// REQ     | BUS_LOAD for the current fetch address until accepted or squashed
// WAIT    | waiting for the latched tag; the fill always completes
// PF_REQ  | next-line request; yields to a demand miss, dropped on squash
// PF_WAIT | waiting for the prefetch tag
module icache_ctrl
  import sys_defs::*;
#(
  parameter int ICACHE_LINES = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [XLEN-1:0]     proc2Icache_addr,
  input  logic                squash_in,
  output logic [63:0]         Icache_data_out,
  output logic                Icache_valid_out,
  icache_ctrl_if.master       mem
);
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;

  icache_state_e    state_q, state_d;
  logic [3:0]       lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
  logic [TAG_W-1:0] lat_line_q, lat_line_d;

  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [63:0]      rd_data;
  logic             wr_en, mid_fill, fill_done;
  logic             unused_addr_bits;

  assign cur_idx          = proc2Icache_addr[3+IDX_W-1:3];
  assign cur_tag          = proc2Icache_addr[XLEN-1:3+IDX_W];
  assign unused_addr_bits = ^proc2Icache_addr[2:0];
  assign fill_done        = (mem.mem2proc_tag == lat_tag_q) && (lat_tag_q != 4'd0);

`ifdef ICACHE_PREFETCH_EN
  logic [XLEN-4:0]  pf_line;
  logic             probe_valid, pf_needed;
  logic [TAG_W-1:0] probe_tag;

  assign pf_line   = {lat_line_q, lat_idx_q} + (XLEN-3)'(1);
  assign pf_needed = !(probe_valid && (probe_tag == pf_line[XLEN-4:IDX_W]));
  assign mid_fill  = ((state_q == WAIT) || (state_q == PF_WAIT)) && (lat_idx_q == cur_idx);
`else
  assign mid_fill  = (state_q == WAIT) && (lat_idx_q == cur_idx);
`endif

  icache_mem #(.LINES(ICACHE_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_mem (
    .clock       (clock),
    .reset       (reset),
    .rd_idx      (cur_idx),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
`ifdef ICACHE_PREFETCH_EN
    .probe_idx   (pf_line[IDX_W-1:0]),
    .probe_valid (probe_valid),
    .probe_tag   (probe_tag),
`endif
    .wr_en       (wr_en),
    .wr_idx      (lat_idx_q),
    .wr_tag      (lat_line_q),
    .wr_data     (mem.mem2proc_data)
  );

  // A line being refilled may still hold an old matching tag; hide it until the fill lands.
  assign Icache_valid_out = rd_valid && (rd_tag == cur_tag) && !mid_fill;
  assign Icache_data_out  = rd_data;

  always_comb begin
    state_d              = state_q;
    lat_tag_d            = lat_tag_q;
    lat_idx_d            = lat_idx_q;
    lat_line_d           = lat_line_q;
    wr_en                = 1'b0;
    mem.proc2mem_command = BUS_NONE;
    mem.proc2mem_addr    = '0;
    case (state_q)
      IDLE: begin
        if (!Icache_valid_out && !squash_in) state_d = REQ;
      end
      REQ: begin
        if (squash_in) begin
          state_d = IDLE;
        end else begin
          mem.proc2mem_command = BUS_LOAD;
          mem.proc2mem_addr    = {proc2Icache_addr[XLEN-1:3], 3'b000};
          if (mem.mem2proc_response != 4'd0) begin
            lat_tag_d  = mem.mem2proc_response;
            lat_idx_d  = cur_idx;
            lat_line_d = cur_tag;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (fill_done) begin
          wr_en   = 1'b1;
          state_d = IDLE;
`ifdef ICACHE_PREFETCH_EN
          if (pf_needed) state_d = PF_REQ;
`endif
        end
      end
`ifdef ICACHE_PREFETCH_EN
      PF_REQ: begin
        if (squash_in) begin
          state_d = IDLE;
        end else if (!Icache_valid_out) begin
          state_d = REQ;
        end else begin
          mem.proc2mem_command = BUS_LOAD;
          mem.proc2mem_addr    = {pf_line, 3'b000};
          if (mem.mem2proc_response != 4'd0) begin
            lat_tag_d  = mem.mem2proc_response;
            lat_idx_d  = pf_line[IDX_W-1:0];
            lat_line_d = pf_line[XLEN-4:IDX_W];
            state_d    = PF_WAIT;
          end
        end
      end
      PF_WAIT: begin
        if (fill_done) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lat_tag_q  <= '0;
      lat_idx_q  <= '0;
      lat_line_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_tag_q  <= lat_tag_d;
      lat_idx_q  <= lat_idx_d;
      lat_line_q <= lat_line_d;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Table-driven, scoreboard-checked bench for icache_ctrl; with ICACHE_PREFETCH_EN defined it
// runs the next-line prefetch sequence instead of the demand-only table.
module tb_icache_ctrl;
  import sys_defs::*;

  typedef struct {
    string           name;
    logic            rst;
    logic [XLEN-1:0] addr;
    logic            sq;
    logic [3:0]      resp;
    logic [3:0]      mtag;
    logic [63:0]     mdata;
    logic            e_valid;
    logic [63:0]     e_data;
    logic            chk_data;
    logic [1:0]      e_cmd;
    logic [XLEN-1:0] e_maddr;
  } vec_t;

  localparam logic [63:0] D1   = 64'h0000000100000000;
  localparam logic [63:0] D2   = 64'hCAFEF00D12345678;
  localparam logic [63:0] D3   = 64'h0123456789ABCDEF;
  localparam logic [63:0] D4   = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] JUNK = 64'hDEADBEEFDEADBEEF;
  localparam logic [1:0]  NONE = BUS_NONE;
  localparam logic [1:0]  LOAD = BUS_LOAD;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] addr;
  logic            sq;
  logic [63:0]     dout;
  logic            vout;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t tbl[$];

  icache_ctrl_if bus();

  icache_ctrl #(.ICACHE_LINES(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2Icache_addr (addr),
    .squash_in        (sq),
    .Icache_data_out  (dout),
    .Icache_valid_out (vout),
    .mem              (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input string n, input logic r, input logic [XLEN-1:0] a,
                              input logic s, input logic [3:0] rp, input logic [3:0] tg,
                              input logic [63:0] d, input logic ev, input logic [63:0] ed,
                              input logic cd, input logic [1:0] ec, input logic [XLEN-1:0] ea);
    vec_t v;
    v.name = n; v.rst = r; v.addr = a; v.sq = s; v.resp = rp; v.mtag = tg; v.mdata = d;
    v.e_valid = ev; v.e_data = ed; v.chk_data = cd; v.e_cmd = ec; v.e_maddr = ea;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then check outputs mid-cycle.
  task automatic apply(input vec_t v);
    vec_t e;
    reset                 = v.rst;
    addr                  = v.addr;
    sq                    = v.sq;
    bus.mem2proc_response = v.resp;
    bus.mem2proc_tag      = v.mtag;
    bus.mem2proc_data     = v.mdata;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    cmp({e.name, ".valid"}, 64'(vout), 64'(e.e_valid));
    if (e.chk_data) cmp({e.name, ".data"}, dout, e.e_data);
    cmp({e.name, ".cmd"},   64'(bus.proc2mem_command), 64'(e.e_cmd));
    cmp({e.name, ".maddr"}, 64'(bus.proc2mem_addr),    64'(e.e_maddr));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; addr = '0; sq = 1'b0;
    bus.mem2proc_response = '0; bus.mem2proc_tag = '0; bus.mem2proc_data = '0;
    @(posedge clock);
    #1;
    apply(mk("rst0", 0, 32'h0,  0, 0, 0, 0,    0, 64'h0, 1, NONE, 32'h0));
    apply(mk("rst1", 0, 32'h18, 0, 3, 3, D2,   0, 64'h0, 1, NONE, 32'h0));
`ifdef ICACHE_PREFETCH_EN
    apply(mk("pf_miss",   1, 32'h20, 0, 0, 0, 0,  0, 0,  0, NONE, 32'h0));
    apply(mk("pf_req20",  1, 32'h20, 0, 3, 0, 0,  0, 0,  0, LOAD, 32'h20));
    apply(mk("pf_fill20", 1, 32'h20, 0, 0, 3, D1, 0, 0,  0, NONE, 32'h0));
    apply(mk("pf_req28",  1, 32'h20, 0, 6, 0, 0,  1, D1, 1, LOAD, 32'h28));
    apply(mk("pf_fill28", 1, 32'h20, 0, 0, 6, D2, 1, D1, 1, NONE, 32'h0));
    apply(mk("pf_hit28",  1, 32'h28, 0, 0, 0, 0,  1, D2, 1, NONE, 32'h0));
`else
    tbl.push_back(mk("idle_miss", 1, 32'h0,   0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("req0",      1, 32'h0,   0, 3, 0, 0,    0, 0,  0, LOAD, 32'h0));
    tbl.push_back(mk("wait_a",    1, 32'h0,   0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("wait_b",    1, 32'h0,   0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("fill0",     1, 32'h0,   0, 0, 3, D1,   0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("hit0",      1, 32'h0,   0, 0, 0, 0,    1, D1, 1, NONE, 32'h0));
    tbl.push_back(mk("miss10",    1, 32'h10,  0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("req10",     1, 32'h10,  0, 0, 0, 0,    0, 0,  0, LOAD, 32'h10));
    tbl.push_back(mk("retarget",  1, 32'h1C,  0, 0, 0, 0,    0, 0,  0, LOAD, 32'h18));
    tbl.push_back(mk("hold18",    1, 32'h18,  0, 0, 0, 0,    0, 0,  0, LOAD, 32'h18));
    tbl.push_back(mk("squash",    1, 32'h18,  1, 5, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("stale5",    1, 32'h0,   0, 0, 5, JUNK, 1, D1, 1, NONE, 32'h0));
    tbl.push_back(mk("no_fill5",  1, 32'h18,  1, 0, 5, JUNK, 0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("miss18",    1, 32'h18,  0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("req18",     1, 32'h18,  0, 2, 0, 0,    0, 0,  0, LOAD, 32'h18));
    tbl.push_back(mk("wait_hit0", 1, 32'h0,   0, 0, 0, 0,    1, D1, 1, NONE, 32'h0));
    tbl.push_back(mk("bad_tag",   1, 32'h18,  0, 0, 7, JUNK, 0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("fill18",    1, 32'h18,  0, 0, 2, D2,   0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("hit18",     1, 32'h18,  0, 0, 0, 0,    1, D2, 1, NONE, 32'h0));
    tbl.push_back(mk("hit1c",     1, 32'h1C,  0, 0, 0, 0,    1, D2, 1, NONE, 32'h0));
    tbl.push_back(mk("miss100",   1, 32'h100, 0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("req100",    1, 32'h100, 0, 4, 0, 0,    0, 0,  0, LOAD, 32'h100));
    tbl.push_back(mk("midfill",   1, 32'h0,   0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("fill100",   1, 32'h100, 0, 0, 4, D3,   0, 0,  0, NONE, 32'h0));
    tbl.push_back(mk("hit100",    1, 32'h100, 0, 0, 0, 0,    1, D3, 1, NONE, 32'h0));
    tbl.push_back(mk("evicted0",  1, 32'h0,   0, 0, 0, 0,    0, 0,  0, NONE, 32'h0));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset during WAIT: the returning tag must not fill, and earlier lines are gone.
    apply(mk("req_rst",     1, 32'h0,  0, 2, 0, 0,  0, 0,     0, LOAD, 32'h0));
    apply(mk("rst_wait",    0, 32'h18, 0, 0, 0, 0,  0, 64'h0, 1, NONE, 32'h0));
    apply(mk("rst_rel",     1, 32'h0,  1, 0, 2, D4, 0, 0,     0, NONE, 32'h0));
    apply(mk("late_tag",    1, 32'h0,  1, 0, 2, D4, 0, 0,     0, NONE, 32'h0));
    apply(mk("line_inv",    1, 32'h18, 1, 0, 0, 0,  0, 0,     0, NONE, 32'h0));
    apply(mk("refetch",     1, 32'h0,  0, 0, 0, 0,  0, 0,     0, NONE, 32'h0));
    apply(mk("refetch_req", 1, 32'h0,  0, 0, 0, 0,  0, 0,     0, LOAD, 32'h0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter ICACHE_LINES, default 32: number of direct-mapped 64-bit lines; power of two, at least 2.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-004 proc2Icache_addr  input  `XLEN  fetch address from ifetch; bits [2:0] ignored.
REQ-005 squash_in  input  1  retire-stage squash; abandons any not-yet-accepted memory request.
REQ-006 Icache_data_out  output  64  line data for proc2Icache_addr.
REQ-007 Icache_valid_out  output  1  Icache_data_out is valid this cycle.
REQ-008 proc2mem_command  output  2  BUS_NONE or BUS_LOAD.
REQ-009 proc2mem_addr  output  `XLEN  8-byte-aligned request address.
REQ-010 mem2proc_response  input  4  nonzero = request accepted, value is the transaction tag; 0 = not accepted.
REQ-011 mem2proc_data  input  64  returned block.
REQ-012 mem2proc_tag  input  4  nonzero = mem2proc_data belongs to this tag.

Function
REQ-013 Index = addr[3+log2(ICACHE_LINES)-1:3]; tag = the remaining upper address bits; each line holds a valid bit, a tag, and 64 data bits.
REQ-014 Hit path is combinational: Icache_valid_out = line valid and tag match, in the same cycle proc2Icache_addr is presented; Icache_data_out = line data.
REQ-015 The FSM has exactly three states: IDLE, REQ, WAIT.
REQ-016 IDLE: on a miss with squash_in=0, go to REQ next cycle; otherwise stay in IDLE.
REQ-017 REQ: drive BUS_LOAD with proc2mem_addr = {proc2Icache_addr[`XLEN-1:3], 3'b0} from the current-cycle address, so a PC change retargets the request.
REQ-018 REQ: on mem2proc_response != 0, latch the tag, index, and line tag, then go to WAIT; on response 0, stay in REQ.
REQ-019 REQ with squash_in=1: drive BUS_NONE that cycle and return to IDLE; squash takes precedence over a simultaneous nonzero response, and that tag is not latched.
REQ-020 WAIT: proc2mem_command = BUS_NONE; when mem2proc_tag equals the latched nonzero tag, write mem2proc_data into the latched index, set valid, and go to IDLE.
REQ-021 WAIT is not affected by squash; the fill always completes.
REQ-022 A filled line becomes visible on the hit path the cycle after the write edge.
REQ-023 Only one outstanding demand transaction is allowed; mem2proc_tag values that do not match the latched tag are ignored.
REQ-024 Icache_valid_out is never asserted for a line that is mid-fill.
REQ-025 proc2mem_addr = 0 whenever proc2mem_command = BUS_NONE.

Reset
REQ-026 While reset=0: all line valid bits clear, FSM in IDLE, latched tag 0, proc2mem_command = BUS_NONE, proc2mem_addr = 0, Icache_valid_out = 0, Icache_data_out = 0.
REQ-027 Reset asserted mid-REQ or mid-WAIT discards the transaction; a later tag return for it is ignored.

Configuration
REQ-028 With ICACHE_PREFETCH_EN defined: after a demand fill completes, if line (filled address + 8) is invalid, the FSM issues one next-line request through states PF_REQ and PF_WAIT with the same handshake as REQ/WAIT.
REQ-029 With ICACHE_PREFETCH_EN defined: a demand miss arriving in PF_REQ preempts the prefetch; squash_in in PF_REQ cancels it.
REQ-030 Without ICACHE_PREFETCH_EN: no prefetch states exist, and behaviour is exactly REQ-015..REQ-025.

Structure
REQ-031 BUS_NONE/BUS_LOAD encoding, `XLEN, and the FSM state enum live in the shared sys_defs package.
REQ-032 The tag/valid/data array is one sub-module, icache_mem (one combinational read port, one synchronous write port, async active-low clear of valid bits).

Verification
REQ-033 Post-reset, addr 0x0 -> Icache_valid_out=0 and BUS_LOAD at addr 0x0 on the next cycle.
REQ-034 Response=3 then two idle cycles, then tag=3 with data 0x0000000100000000 -> the next cycle addr 0x0 hits with that data.
REQ-035 In REQ with response held 0, change addr 0x10 to 0x18 -> proc2mem_addr follows to 0x18.
REQ-036 squash_in=1 with response=5 in the same REQ cycle -> BUS_NONE, IDLE, and a later tag=5 causes no fill.
REQ-037 reset=0 during WAIT (tag 2), then tag=2 returns -> line stays invalid and Icache_valid_out=0.
REQ-038 ICACHE_PREFETCH_EN defined, fill of 0x20 completes -> BUS_LOAD at 0x28 next cycle; then 0x28 hits after its fill.
